// File: rtl/deb_pkg.sv
// Shared types and helpers for the input debouncer and its synchroniser.
package deb_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } deb_state_e;

  // Counter must hold values up to STABLE_CYCLES.
  function automatic int unsigned cnt_w(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser for a single asynchronous level.
module sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Synchronises and debounces an asynchronous level; counts aborted qualifications.
module sig_debounce
  import deb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned GLITCH_W      = 8,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig_async,
  input  logic                glitch_clr,
  output logic                sig_clean,
  output logic                bouncing,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned      CNT_W    = cnt_w(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic s;

  deb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                clean_q, clean_d;
  logic                bouncing_q, bouncing_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                abort;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_async),
    .q   (s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clean_d    = clean_q;
    bouncing_d = bouncing_q;
    abort      = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (s != clean_q) begin
          if (STABLE_CYCLES == 1) begin
            clean_d = s;
          end else begin
            cnt_d      = CNT_W'(1);
            bouncing_d = 1'b1;
            state_d    = ST_QUALIFY;
          end
        end
      end
      ST_QUALIFY: begin
        if (s == clean_q) begin
          // Level fell back before qualifying: discard all progress.
          cnt_d      = '0;
          bouncing_d = 1'b0;
          abort      = 1'b1;
          state_d    = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          clean_d    = s;
          cnt_d      = '0;
          bouncing_d = 1'b0;
          state_d    = ST_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  // Clear wins over a coincident abort; count saturates at all-ones.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STABLE;
      cnt_q      <= '0;
      clean_q    <= RESET_VAL;
      bouncing_q <= 1'b0;
      glitch_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clean_q    <= clean_d;
      bouncing_q <= bouncing_d;
      glitch_q   <= glitch_d;
    end
  end

  assign sig_clean  = clean_q;
  assign bouncing   = bouncing_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sig_debounce.sv
// Bench for sig_debounce: three configurations against a run-length reference model.
module tb_sig_debounce;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] sig_async;
  logic [2:0] glitch_clr;
  logic [2:0] clean;
  logic [2:0] bouncing;
  logic [7:0] g0;
  logic [1:0] g1;
  logic [7:0] g2;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // u0: default test config; u1: narrow glitch counter; u2: single-cycle qualification.
  sig_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(8), .RESET_VAL(1'b0)) u0 (
    .clk(clk), .rst(rst[0]), .sig_async(sig_async[0]), .glitch_clr(glitch_clr[0]),
    .sig_clean(clean[0]), .bouncing(bouncing[0]), .glitch_cnt(g0)
  );
  sig_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(2), .RESET_VAL(1'b0)) u1 (
    .clk(clk), .rst(rst[1]), .sig_async(sig_async[1]), .glitch_clr(glitch_clr[1]),
    .sig_clean(clean[1]), .bouncing(bouncing[1]), .glitch_cnt(g1)
  );
  sig_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GLITCH_W(8), .RESET_VAL(1'b0)) u2 (
    .clk(clk), .rst(rst[2]), .sig_async(sig_async[2]), .glitch_clr(glitch_clr[2]),
    .sig_clean(clean[2]), .bouncing(bouncing[2]), .glitch_cnt(g2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: delay line for the synchroniser, then a run length of
  // consecutive samples differing from the clean level.
  int m_stable[3] = '{4, 4, 1};
  int m_gmax[3]   = '{255, 3, 255};
  bit [1:0] m_hist[3];
  bit m_clean[3];
  int m_run[3];
  int m_glitch[3];

  initial begin
    bit s;
    bit ab;
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = 2'b00; m_clean[i] = 1'b0; m_run[i] = 0; m_glitch[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst[i]) begin
          m_hist[i] = 2'b00; m_clean[i] = 1'b0; m_run[i] = 0; m_glitch[i] = 0;
        end else begin
          s  = m_hist[i][1];
          ab = 1'b0;
          if (s != m_clean[i]) begin
            m_run[i]++;
            if (m_run[i] == m_stable[i]) begin
              m_clean[i] = s;
              m_run[i]   = 0;
            end
          end else begin
            ab       = (m_run[i] > 0);
            m_run[i] = 0;
          end
          if (glitch_clr[i]) m_glitch[i] = 0;
          else if (ab && m_glitch[i] < m_gmax[i]) m_glitch[i]++;
          m_hist[i] = {m_hist[i][0], sig_async[i]};
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] act_glitch(input int i);
    if (i == 0) return {24'd0, g0};
    if (i == 1) return {30'd0, g1};
    return {24'd0, g2};
  endfunction

  // Per-cycle comparison against the model, clear of the input drive instant.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("u%0d sig_clean", i), {31'd0, clean[i]},
                rst[i] ? 32'd0 : {31'd0, m_clean[i]});
          check($sformatf("u%0d bouncing", i), {31'd0, bouncing[i]},
                (rst[i] || m_run[i] == 0) ? 32'd0 : 32'd1);
          check($sformatf("u%0d glitch_cnt", i), act_glitch(i),
                rst[i] ? 32'd0 : 32'(m_glitch[i]));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_inst(input int i);
    rst[i] = 1'b1; sig_async[i] = 1'b0; glitch_clr[i] = 1'b0;
    tick(2);
    rst[i] = 1'b0;
  endtask

  int pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    rst = 3'b111; sig_async = 3'b000; glitch_clr = 3'b000;
    tick(3);
    chk_en = 1;

    // Reset held while the input toggles.
    for (int k = 0; k < 6; k++) begin
      sig_async[0] = ~sig_async[0];
      tick(1);
      check("rst clean", {31'd0, clean[0]}, 32'd0);
      check("rst bouncing", {31'd0, bouncing[0]}, 32'd0);
      check("rst glitch", act_glitch(0), 32'd0);
    end
    sig_async[0] = 1'b0;
    tick(1);
    rst = 3'b000;

    // Clean step: bouncing after edges 3..5, sig_clean after edge 6.
    sig_async[0] = 1'b1;
    tick(3);
    check("step e3 bouncing", {31'd0, bouncing[0]}, 32'd1);
    check("step e3 clean", {31'd0, clean[0]}, 32'd0);
    tick(2);
    check("step e5 bouncing", {31'd0, bouncing[0]}, 32'd1);
    check("step e5 clean", {31'd0, clean[0]}, 32'd0);
    tick(1);
    check("step e6 clean", {31'd0, clean[0]}, 32'd1);
    check("step e6 bouncing", {31'd0, bouncing[0]}, 32'd0);

    // Two-cycle glitch.
    reset_inst(0);
    sig_async[0] = 1'b1;
    tick(2);
    sig_async[0] = 1'b0;
    tick(6);
    check("glitch clean", {31'd0, clean[0]}, 32'd0);
    check("glitch cnt", act_glitch(0), 32'd1);

    // Bounce rising then falling.
    reset_inst(0);
    for (int k = 0; k < 9; k++) begin
      sig_async[0] = pat[k][0];
      tick(1);
    end
    check("bounce rise e9 clean", {31'd0, clean[0]}, 32'd0);
    tick(1);
    check("bounce rise e10 clean", {31'd0, clean[0]}, 32'd0);
    tick(1);
    check("bounce rise e11 clean", {31'd0, clean[0]}, 32'd1);
    check("bounce rise glitch", act_glitch(0), 32'd2);
    check("bounce rise bouncing", {31'd0, bouncing[0]}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      sig_async[0] = ~pat[k][0];
      tick(1);
    end
    tick(1);
    check("bounce fall e10 clean", {31'd0, clean[0]}, 32'd1);
    tick(1);
    check("bounce fall e11 clean", {31'd0, clean[0]}, 32'd0);
    check("bounce fall glitch", act_glitch(0), 32'd4);

    // Saturation of a 2-bit counter, then clear coincident with an abort.
    for (int k = 0; k < 5; k++) begin
      sig_async[1] = 1'b1;
      tick(1);
      sig_async[1] = 1'b0;
      tick(5);
    end
    check("sat glitch", act_glitch(1), 32'd3);
    sig_async[1] = 1'b1;
    tick(1);
    sig_async[1] = 1'b0;
    tick(2);
    check("clr pre bouncing", {31'd0, bouncing[1]}, 32'd1);
    glitch_clr[1] = 1'b1;
    tick(1);
    glitch_clr[1] = 1'b0;
    check("clr glitch", act_glitch(1), 32'd0);
    check("clr bouncing", {31'd0, bouncing[1]}, 32'd0);

    // Asynchronous reset in the middle of qualification.
    reset_inst(0);
    sig_async[0] = 1'b1;
    tick(4);
    check("midq bouncing", {31'd0, bouncing[0]}, 32'd1);
    #2 rst[0] = 1'b1;
    #1;
    check("midq async bouncing", {31'd0, bouncing[0]}, 32'd0);
    check("midq async clean", {31'd0, clean[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    tick(5);
    check("midq e5 clean", {31'd0, clean[0]}, 32'd0);
    tick(1);
    check("midq e6 clean", {31'd0, clean[0]}, 32'd1);

    // Single-cycle qualification follows at edge 3.
    reset_inst(2);
    sig_async[2] = 1'b1;
    tick(2);
    check("sc1 e2 clean", {31'd0, clean[2]}, 32'd0);
    tick(1);
    check("sc1 e3 clean", {31'd0, clean[2]}, 32'd1);
    check("sc1 e3 bouncing", {31'd0, bouncing[2]}, 32'd0);
    sig_async[2] = 1'b0;
    tick(3);
    check("sc1 fall clean", {31'd0, clean[2]}, 32'd0);

    tick(2);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
